// File: rtl/cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm
// Control sequencer for the simple 16-bit CPU. Sits downstream of the
// instruction decoder, takes the decoded {opcode, op} and steps the datapath
// through register reads, the ALU cycle and writeback. Uses a start/wait
// handshake with the top level.
//
// Supported: MOV #imm8 (110/10), MOV Rd,Rm{,sh} (110/00), ADD (101/00),
// CMP (101/01), AND (101/10), MVN (101/11). Every other encoding raises err
// for one cycle and the FSM returns to WAIT.
//
// Optional feature macro: CTRL_ICOUNT_EN
//   defined   -> icount port and retired-instruction counter present
//   undefined -> no icount port, no counter
//
// Ports
//   clk     in   1         rising-edge clock
//   reset   in   1         asynchronous, active-high reset
//   s       in   1         start request, sampled only in WAIT
//   opcode  in   3         instruction bits [15:13]
//   op      in   2         instruction bits [12:11]
//   w       out  1         ready; high only in WAIT
//   nsel    out  3         one-hot reg select: 001 Rn, 010 Rd, 100 Rm
//   loada   out  1         load A register
//   loadb   out  1         load B register
//   loadc   out  1         load C register
//   loads   out  1         load status register
//   asel    out  1         ALU A operand forced to 0
//   bsel    out  1         ALU B operand is sximm5
//   vsel    out  2         writeback source: 00 C, 10 sximm8
//   write   out  1         register-file write enable
//   err     out  1         illegal encoding, single DECODE cycle
//   icount  out  ICOUNT_W  retired instructions (CTRL_ICOUNT_EN only)
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm #(
   parameter int unsigned ICOUNT_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       w,
   output logic [2:0] nsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic [1:0] vsel,
   output logic       write,
   output logic       err
`ifdef CTRL_ICOUNT_EN
   ,
   output logic [ICOUNT_W-1:0] icount
`endif
);

   if (ICOUNT_W == 0) begin : g_bad_icount_w
      $error("cpu_ctrl_fsm: ICOUNT_W must be at least 1");
   end

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_DECODE,
      ST_WR_IMM,
      ST_GET_A,
      ST_GET_B,
      ST_ALU,
      ST_WR_REG
   } state_t;

   localparam logic [2:0] NSEL_RN = 3'b001;
   localparam logic [2:0] NSEL_RD = 3'b010;
   localparam logic [2:0] NSEL_RM = 3'b100;

   state_t     r_state;
   state_t     w_next;
   logic [4:0] r_instr;

   logic       w_is_movimm;
   logic       w_is_movreg;
   logic       w_is_alu;
   logic       w_is_cmp;

   // Instruction is captured on the same edge that accepts s, so DECODE and
   // every later state see a stable copy regardless of what the decoder does.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr <= '0;
      end else if (r_state == ST_WAIT && s) begin
         r_instr <= {opcode, op};
      end
   end

   always_comb begin
      w_is_movimm = (r_instr == 5'b110_10);
      w_is_movreg = (r_instr == 5'b110_00);
      w_is_alu    = (r_instr[4:2] == 3'b101);
      w_is_cmp    = (r_instr == 5'b101_01);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_WAIT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w      = 1'b0;
      nsel   = NSEL_RN;
      loada  = 1'b0;
      loadb  = 1'b0;
      loadc  = 1'b0;
      loads  = 1'b0;
      asel   = 1'b0;
      bsel   = 1'b0;
      vsel   = 2'b00;
      write  = 1'b0;
      err    = 1'b0;

      unique case (r_state)
         ST_WAIT: begin
            w = 1'b1;
            if (s) begin
               w_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (w_is_movimm) begin
               w_next = ST_WR_IMM;
            end else if (w_is_movreg) begin
               w_next = ST_GET_B;
            end else if (w_is_alu) begin
               w_next = ST_GET_A;
            end else begin
               err    = 1'b1;
               w_next = ST_WAIT;
            end
         end
         ST_WR_IMM: begin
            nsel   = NSEL_RN;
            vsel   = 2'b10;
            write  = 1'b1;
            w_next = ST_WAIT;
         end
         ST_GET_A: begin
            nsel   = NSEL_RN;
            loada  = 1'b1;
            w_next = ST_GET_B;
         end
         ST_GET_B: begin
            nsel   = NSEL_RM;
            loadb  = 1'b1;
            w_next = ST_ALU;
         end
         ST_ALU: begin
            loadc  = 1'b1;
            asel   = w_is_movreg;
            loads  = w_is_cmp;
            w_next = w_is_cmp ? ST_WAIT : ST_WR_REG;
         end
         ST_WR_REG: begin
            nsel   = NSEL_RD;
            vsel   = 2'b00;
            write  = 1'b1;
            w_next = ST_WAIT;
         end
         default: begin
            w_next = ST_WAIT;
         end
      endcase
   end

`ifdef CTRL_ICOUNT_EN
   logic                w_retire;
   logic [ICOUNT_W-1:0] r_icount;

   // An instruction retires on the edge leaving its last state: WR_IMM,
   // WR_REG, or ALU when the op is CMP (no writeback cycle).
   always_comb begin
      w_retire = (r_state == ST_WR_IMM) || (r_state == ST_WR_REG) ||
                 (r_state == ST_ALU && w_is_cmp);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_icount <= '0;
      end else if (w_retire) begin
         r_icount <= r_icount + ICOUNT_W'(1);
      end
   end

   assign icount = r_icount;
`endif

endmodule
